// File: rtl/cas_sort_pipe.sv
// rtl/cas_sort_pipe.sv - pipelined odd-even transposition sorter with index tags and valid/ready flow control
module cas_sort_pipe #(
    parameter int WIDTH    = 6,
    parameter int N_INPUTS = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_INPUTS*WIDTH-1:0]             in_data,
    input  logic                                  in_mode,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [N_INPUTS*WIDTH-1:0]             out_data,
    output logic [N_INPUTS*$clog2(N_INPUTS)-1:0]  out_idx,
    output logic                                  out_mode,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    localparam int IDX_W = $clog2(N_INPUTS);

    // Single global enable: the whole pipe moves together or holds together.
    logic adv;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < N_INPUTS; s++) begin : g_stage
        logic [WIDTH-1:0] src_dat [N_INPUTS];
        logic [IDX_W-1:0] src_idx [N_INPUTS];
        logic             src_mode;
        logic             src_vld;
        logic [WIDTH-1:0] dat_d   [N_INPUTS];
        logic [IDX_W-1:0] idx_d   [N_INPUTS];
        logic [WIDTH-1:0] dat_q   [N_INPUTS];
        logic [IDX_W-1:0] idx_q   [N_INPUTS];
        logic             mode_q;
        logic             vld_q;

        if (s == 0) begin : g_src_in
            // Stage 0 sorts straight off the input bus and tags each lane with its position.
            always_comb begin
                for (int l = 0; l < N_INPUTS; l++) begin
                    src_dat[l] = in_data[l*WIDTH +: WIDTH];
                    src_idx[l] = IDX_W'(l);
                end
                src_mode = in_mode;
                src_vld  = in_valid;
            end
        end else begin : g_src_prev
            // Later stages take the previous layer's registers.
            always_comb begin
                for (int l = 0; l < N_INPUTS; l++) begin
                    src_dat[l] = g_stage[s-1].dat_q[l];
                    src_idx[l] = g_stage[s-1].idx_q[l];
                end
                src_mode = g_stage[s-1].mode_q;
                src_vld  = g_stage[s-1].vld_q;
            end
        end

        // One transposition layer: even stages pair (0,1),(2,3)..; odd stages pair (1,2),(3,4)..
        // Strict compares only, so equal words keep their order and the sort is stable.
        always_comb begin
            for (int l = 0; l < N_INPUTS; l++) begin
                dat_d[l] = src_dat[l];
                idx_d[l] = src_idx[l];
            end
            for (int l = s % 2; l + 1 < N_INPUTS; l += 2) begin
                if (src_mode ? (src_dat[l] > src_dat[l+1]) : (src_dat[l] < src_dat[l+1])) begin
                    dat_d[l]   = src_dat[l+1];
                    dat_d[l+1] = src_dat[l];
                    idx_d[l]   = src_idx[l+1];
                    idx_d[l+1] = src_idx[l];
                end
            end
        end

        // Stage register; bubbles load too, and everything holds while the output is stalled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int l = 0; l < N_INPUTS; l++) begin
                    dat_q[l] <= '0;
                    idx_q[l] <= '0;
                end
                mode_q <= 1'b0;
                vld_q  <= 1'b0;
            end else if (adv) begin
                for (int l = 0; l < N_INPUTS; l++) begin
                    dat_q[l] <= dat_d[l];
                    idx_q[l] <= idx_d[l];
                end
                mode_q <= src_mode;
                vld_q  <= src_vld;
            end
        end
    end

    // Outputs are the last stage's registers repacked onto flat buses.
    always_comb begin
        out_data = '0;
        out_idx  = '0;
        for (int l = 0; l < N_INPUTS; l++) begin
            out_data[l*WIDTH +: WIDTH] = g_stage[N_INPUTS-1].dat_q[l];
            out_idx[l*IDX_W +: IDX_W]  = g_stage[N_INPUTS-1].idx_q[l];
        end
    end

    assign out_mode  = g_stage[N_INPUTS-1].mode_q;
    assign out_valid = g_stage[N_INPUTS-1].vld_q;

endmodule
